// File: rtl/vx_gbar_unit.sv
// vx_gbar_unit: cluster-level global barrier responder.
//   Target of the gbar bus driven by each socket's gbar arbiter. Keeps a
//   per-barrier arrival mask of cores. When a request brings the arrived
//   count up to the requested size, a one-cycle release pulse carrying the
//   barrier id goes out on the next cycle and the slot is cleared.
//
// Ports:
//   clk, reset        clock, synchronous active-high reset
//   req_valid/ready   arrival handshake (ready is 1 whenever not in reset)
//   req_id            barrier id
//   req_size_m1       participating core count minus one
//   req_core_id       arriving core id
//   rsp_valid/rsp_id  release broadcast pulse (no backpressure)
//   busy              any arrival mask non-empty or release pending
//
// Optional: define VX_GBAR_PERF_EN to add perf_releases (wrapping release
// count) and perf_wait_cycles (saturating count of cycles with any mask set).

// One barrier slot: holds the arrival mask for a single barrier id.
module vx_gbar_slot #(
  parameter int NUM_CORES = 4
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 wr,
  input  logic [NUM_CORES-1:0] nxt,
  output logic [NUM_CORES-1:0] mask
);
  always_ff @(posedge clk) begin
    if (reset)   mask <= '0;
    else if (wr) mask <= nxt;
  end
endmodule

module vx_gbar_unit #(
  parameter  int NUM_BARRIERS = 16,
  parameter  int NUM_CORES    = 4,
  localparam int NB_BITS      = (NUM_BARRIERS > 1) ? $clog2(NUM_BARRIERS) : 1,
  localparam int NC_BITS      = (NUM_CORES > 1) ? $clog2(NUM_CORES) : 1
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               req_valid,
  input  logic [NB_BITS-1:0] req_id,
  input  logic [NC_BITS-1:0] req_size_m1,
  input  logic [NC_BITS-1:0] req_core_id,
  output logic               req_ready,
  output logic               rsp_valid,
  output logic [NB_BITS-1:0] rsp_id,
`ifdef VX_GBAR_PERF_EN
  output logic [31:0]        perf_releases,
  output logic [31:0]        perf_wait_cycles,
`endif
  output logic               busy
);
  localparam int CW = NC_BITS + 1;

  typedef struct packed {
    logic [NB_BITS-1:0] id;
    logic [NC_BITS-1:0] size_m1;
    logic [NC_BITS-1:0] core_id;
  } req_t;

  function automatic logic [CW-1:0] popcnt(input logic [NUM_CORES-1:0] m);
    popcnt = '0;
    for (int i = 0; i < NUM_CORES; i++) popcnt = popcnt + CW'(m[i]);
  endfunction

  req_t                                 req;
  logic [NUM_BARRIERS-1:0][NUM_CORES-1:0] masks;
  logic                                 accept, id_ok, core_ok, do_op, release_hit;
  logic [NUM_CORES-1:0]                 cur_mask, core_bit, new_mask, slot_nxt;
  logic [CW-1:0]                        cnt, need;
  logic                                 any_mask;
  logic                                 rsp_valid_r;
  logic [NB_BITS-1:0]                   rsp_id_r;

  assign req     = '{id: req_id, size_m1: req_size_m1, core_id: req_core_id};
  assign accept  = req_valid && req_ready;
  // Out-of-range ids/cores are accepted but leave all state untouched.
  assign id_ok   = (32'(req.id) < NUM_BARRIERS);
  assign core_ok = (32'(req.core_id) < NUM_CORES);
  assign do_op   = accept && id_ok && core_ok;

  always_comb begin
    cur_mask = '0;
    core_bit = '0;
    if (id_ok)   cur_mask = masks[req.id];
    if (core_ok) core_bit[req.core_id] = 1'b1;
    new_mask = cur_mask | core_bit;
  end

  // Duplicate arrivals leave new_mask == cur_mask, so they only release
  // when the count was already met. The completing request's size wins.
  assign cnt         = popcnt(new_mask);
  assign need        = CW'(req.size_m1) + CW'(1);
  assign release_hit = do_op && (cnt == need);
  assign slot_nxt    = release_hit ? '0 : new_mask;

  for (genvar b = 0; b < NUM_BARRIERS; b++) begin : g_slot
    vx_gbar_slot #(.NUM_CORES(NUM_CORES)) slot_i (
      .clk   (clk),
      .reset (reset),
      .wr    (do_op && (32'(req.id) == b)),
      .nxt   (slot_nxt),
      .mask  (masks[b])
    );
  end

  assign any_mask = |masks;

  always_ff @(posedge clk) begin
    if (reset) begin
      rsp_valid_r <= 1'b0;
      rsp_id_r    <= '0;
    end else begin
      rsp_valid_r <= release_hit;
      if (release_hit) rsp_id_r <= req.id;
    end
  end

  // Outputs are forced idle while reset is high, which also suppresses a
  // release that was registered the cycle before reset arrived.
  assign req_ready = !reset;
  assign rsp_valid = rsp_valid_r && !reset;
  assign rsp_id    = reset ? '0 : rsp_id_r;
  assign busy      = !reset && (any_mask || rsp_valid_r);

`ifdef VX_GBAR_PERF_EN
  always_ff @(posedge clk) begin
    if (reset) begin
      perf_releases    <= '0;
      perf_wait_cycles <= '0;
    end else begin
      if (rsp_valid_r) perf_releases <= perf_releases + 32'd1;
      if (any_mask && (perf_wait_cycles != '1))
        perf_wait_cycles <= perf_wait_cycles + 32'd1;
    end
  end
`endif

`ifndef SYNTHESIS
  // Size of the first arrival, kept only to flag inconsistent sizes.
  logic [NUM_BARRIERS-1:0][NC_BITS-1:0] size_r;

  always_ff @(posedge clk) begin
    if (reset) size_r <= '0;
    else if (do_op && (cur_mask == '0)) size_r[req.id] <= req.size_m1;
  end

  always_ff @(posedge clk) begin
    if (!reset && accept) begin
      assert (id_ok) else $error("gbar: req_id %0d out of range", req.id);
      assert (core_ok) else $error("gbar: req_core_id %0d out of range", req.core_id);
      if (id_ok && core_ok && (cur_mask != '0))
        assert (req.size_m1 == size_r[req.id])
          else $error("gbar: size mismatch on barrier %0d", req.id);
    end
  end
`endif
endmodule

// File: tb/tb_vx_gbar_unit.sv
module tb_vx_gbar_unit;
  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       req_valid = 1'b0;
  logic [3:0] req_id = '0;
  logic [1:0] req_size_m1 = '0;
  logic [1:0] req_core_id = '0;
  logic       req_ready, rsp_valid, busy;
  logic [3:0] rsp_id;
`ifdef VX_GBAR_PERF_EN
  logic [31:0] perf_releases, perf_wait_cycles;
`endif

  vx_gbar_unit #(.NUM_BARRIERS(16), .NUM_CORES(4)) dut (
    .clk              (clk),
    .reset            (reset),
    .req_valid        (req_valid),
    .req_id           (req_id),
    .req_size_m1      (req_size_m1),
    .req_core_id      (req_core_id),
    .req_ready        (req_ready),
    .rsp_valid        (rsp_valid),
    .rsp_id           (rsp_id),
`ifdef VX_GBAR_PERF_EN
    .perf_releases    (perf_releases),
    .perf_wait_cycles (perf_wait_cycles),
`endif
    .busy             (busy)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errs   = 0;
  int cyc    = 0;
  int unexp  = 0;

  typedef struct {int id; int cyc;} exp_t;
  exp_t sb[$];

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errs++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  always @(posedge clk) cyc <= cyc + 1;

  // Scoreboard: every release pulse must match the oldest expectation,
  // both in id and in the cycle it was due.
  always @(negedge clk) begin
    exp_t e;
    if (rsp_valid === 1'b1) begin
      if (sb.size() == 0) unexp++;
      else begin
        e = sb.pop_front();
        chk("rsp_id", 32'(rsp_id), e.id);
        chk("rsp_cyc", cyc, e.cyc);
      end
    end
  end

  // Drive one request for one cycle; called at posedge+1, returns at posedge+1.
  task automatic send(input int id, input int sz, input int core, input bit rel);
    logic [31:0] v_id, v_sz, v_core;
    v_id = id; v_sz = sz; v_core = core;
    req_valid   = 1'b1;
    req_id      = v_id[3:0];
    req_size_m1 = v_sz[1:0];
    req_core_id = v_core[1:0];
    if (rel) sb.push_back('{id, cyc + 1});
    @(posedge clk); #1;
    req_valid = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) begin @(posedge clk); #1; end
  endtask

  initial begin
    // 1: reset held three cycles
    repeat (3) begin
      @(negedge clk);
      chk("rst_ready", 32'(req_ready), 0);
      chk("rst_rsp_valid", 32'(rsp_valid), 0);
      chk("rst_busy", 32'(busy), 0);
    end
    @(posedge clk); #1;
    reset = 1'b0;
    @(negedge clk);
    chk("post_rst_ready", 32'(req_ready), 1);
    chk("post_rst_rsp_valid", 32'(rsp_valid), 0);
    chk("post_rst_busy", 32'(busy), 0);
    chk("post_rst_rsp_id", 32'(rsp_id), 0);
    @(posedge clk); #1;

    // 2: four cores complete barrier 5
    send(5, 3, 0, 0);
    send(5, 3, 1, 0);
    send(5, 3, 2, 0);
    send(5, 3, 3, 1);
    @(negedge clk);
    chk("t2_busy_pending", 32'(busy), 1);
    @(posedge clk); #1;
    @(negedge clk);
    chk("t2_busy_done", 32'(busy), 0);
    @(posedge clk); #1;

    // 3: duplicate arrival does not count
    send(2, 1, 1, 0);
    @(negedge clk);
    chk("t3_mask", 32'(dut.masks[2]), 32'b0010);
    chk("t3_busy", 32'(busy), 1);
    @(posedge clk); #1;
    send(2, 1, 1, 0);
    @(negedge clk);
    chk("t3_mask_dup", 32'(dut.masks[2]), 32'b0010);
    @(posedge clk); #1;
    send(2, 1, 3, 1);
    idle(2);

    // 4: size one releases immediately, back to back
    send(7, 0, 0, 1);
    send(8, 0, 2, 1);
    @(negedge clk);
    chk("t4_mask7", 32'(dut.masks[7]), 0);
    chk("t4_mask8", 32'(dut.masks[8]), 0);
    @(posedge clk); #1;
    idle(2);

    // 5: slot reused on the cycle right after release
    send(4, 1, 0, 0);
    send(4, 1, 1, 1);
    send(4, 1, 0, 0);
    @(negedge clk);
    chk("t5_mask", 32'(dut.masks[4]), 32'b0001);
    chk("t5_busy", 32'(busy), 1);
    @(posedge clk); #1;
    send(4, 1, 2, 1);
    idle(2);
    @(negedge clk);
    chk("t5_busy_done", 32'(busy), 0);
    @(posedge clk); #1;

    // 6: reset mid-barrier discards earlier arrivals
    send(1, 2, 0, 0);
    send(1, 2, 1, 0);
    reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    send(1, 2, 2, 0);
    @(negedge clk);
    chk("t6_mask", 32'(dut.masks[1]), 32'b0100);
`ifdef VX_GBAR_PERF_EN
    chk("t6_perf_rel", perf_releases, 0);
`endif
    @(posedge clk); #1;
    send(1, 2, 0, 0);
    send(1, 2, 1, 1);
    idle(2);
`ifdef VX_GBAR_PERF_EN
    @(negedge clk);
    chk("t6_perf_rel_one", perf_releases, 1);
    @(posedge clk); #1;
`endif

    // 7: reset right after a completing request suppresses its pulse
    send(9, 0, 0, 0);
    reset = 1'b1;
    @(negedge clk);
    chk("t7_rsp_suppr", 32'(rsp_valid), 0);
    chk("t7_busy", 32'(busy), 0);
    @(posedge clk); #1;
    reset = 1'b0;
    @(negedge clk);
    chk("t7_rsp_after", 32'(rsp_valid), 0);
    chk("t7_ready", 32'(req_ready), 1);
    @(posedge clk); #1;

    idle(3);
    chk("sb_empty", 32'(sb.size()), 0);
    chk("unexp_rsp", 32'(unexp), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errs);
    $finish;
  end
endmodule
